// File: rtl/fir_decim.sv
// fir_decim -- integrate-and-dump decimator for the FIR output frame.
//
// Accepts a FRAME-sample stream (valid/ready), sums groups of R = ratio+1
// samples, arithmetically right-shifts each group sum by 'shift' and queues
// the result in a FIFO_DEPTH-entry output FIFO. A trailing partial group is
// flushed as its own result at the end of the frame.
//
// Build option: define FIR_DECIM_SAT_EN to clamp results to the signed DW
// range (sat_flag reports a clamp). When undefined, results wrap to DW bits
// and sat_flag is tied low.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   reset      asynchronous active-low reset
//   start      one-cycle pulse, starts a new frame from any state
//   ratio      decimation ratio minus one, latched on start
//   shift      arithmetic right shift of each group sum, latched on start
//   in_valid / in_data / in_ready     input sample stream
//   out_valid / out_data / out_ready  FIFO head stream (out_data 0 when empty)
//   frame_done frame fully processed, held until the next start
//   sat_flag   sticky per-frame saturation indicator
//   level      FIFO occupancy
//
// state | meaning
// IDLE  | after reset, waiting for start, no input accepted
// RUN   | accepting samples while the FIFO has room
// FLUSH | frame consumed, pushing the pending partial group
// DONE  | frame finished, waiting for start
module fir_decim #(
  parameter int DW         = 32,
  parameter int FRAME      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [3:0]                      ratio,
  input  logic [3:0]                      shift,
  input  logic                            in_valid,
  input  logic [DW-1:0]                   in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  output logic [DW-1:0]                   out_data,
  input  logic                            out_ready,
  output logic                            frame_done,
  output logic                            sat_flag,
  output logic [$clog2(FIFO_DEPTH):0]     level
);

  localparam int AW = DW + 4;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FRAME + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state_q, state_d;

  logic [3:0]            ratio_q;
  logic [3:0]            shift_q;
  logic signed [AW-1:0]  acc_q;
  logic [3:0]            g_left_q;
  logic [NW-1:0]         n_left_q;

  logic [DW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           level_q;

  logic                  fifo_full;
  logic                  accept;
  logic                  grp_end;
  logic                  frm_end;
  logic                  flush_push;
  logic                  push;
  logic                  pop;
  logic signed [AW-1:0]  sum;
  logic signed [AW-1:0]  grp_val;
  logic [DW-1:0]         res_data;

  assign fifo_full  = (level_q == (PW+1)'(FIFO_DEPTH));
  assign in_ready   = (state_q == RUN) && !fifo_full;
  // An input presented together with start is dropped.
  assign accept     = in_valid && in_ready && !start;
  assign sum        = acc_q + AW'($signed(in_data));
  // g_left counts down the samples still needed to close the group.
  assign grp_end    = accept && (g_left_q == 4'd0);
  assign frm_end    = accept && (n_left_q == NW'(1));
  assign flush_push = (state_q == FLUSH) && !fifo_full && !start;
  assign push       = grp_end || flush_push;
  assign pop        = out_valid && out_ready;
  assign grp_val    = (state_q == FLUSH) ? acc_q : sum;

`ifdef FIR_DECIM_SAT_EN
  localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0] shifted;
  logic                 clamp;
  logic                 sat_q;

  assign shifted = grp_val >>> shift_q;

  always_comb begin
    clamp    = 1'b0;
    res_data = shifted[DW-1:0];
    if (shifted > SMAX) begin
      clamp    = 1'b1;
      res_data = {1'b0, {(DW-1){1'b1}}};
    end else if (shifted < SMIN) begin
      clamp    = 1'b1;
      res_data = {1'b1, {(DW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_q <= 1'b0;
    end else if (start) begin
      sat_q <= 1'b0;
    end else if (push && clamp) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag = sat_q;
`else
  assign res_data = DW'(grp_val >>> shift_q);
  assign sat_flag = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (frm_end) state_d = grp_end ? DONE : FLUSH;
        end
        FLUSH: begin
          if (flush_push) state_d = DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ratio_q  <= 4'd0;
      shift_q  <= 4'd0;
      acc_q    <= '0;
      g_left_q <= 4'd0;
      n_left_q <= '0;
    end else if (start) begin
      ratio_q  <= ratio;
      shift_q  <= shift;
      acc_q    <= '0;
      g_left_q <= ratio;
      n_left_q <= NW'(FRAME);
    end else if (accept) begin
      if (grp_end) begin
        acc_q    <= '0;
        g_left_q <= ratio_q;
      end else begin
        acc_q    <= sum;
        g_left_q <= g_left_q - 4'd1;
      end
      n_left_q <= n_left_q - NW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (start) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      level_q <= level_q + (PW+1)'(1);
      else if (pop && !push) level_q <= level_q - (PW+1)'(1);
    end
  end

  // Storage needs no reset: out_data is masked to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= res_data;
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem[rd_ptr_q] : '0;
  assign frame_done = (state_q == DONE);
  assign level      = level_q;

endmodule

// File: tb/tb_fir_decim.sv
module tb_fir_decim;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ratio;
  logic [3:0]  shift;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        frame_done;
  logic        sat_flag;
  logic [2:0]  level;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  logic [31:0] outq[$];
  int          popc[$];
  int          accc[$];

  fir_decim dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ratio      (ratio),
    .shift      (shift),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .sat_flag   (sat_flag),
    .level      (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && out_valid && out_ready) begin
      outq.push_back(out_data);
      popc.push_back(cyc);
    end
    if (reset && in_valid && in_ready && !start) accc.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] r, input logic [3:0] s);
    outq.delete();
    popc.delete();
    accc.delete();
    start = 1'b1;
    ratio = r;
    shift = s;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] v);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) chk("feed_timeout_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    int w;
    w = 0;
    while (outq.size() < n && w < 300) begin
      tick();
      w++;
    end
    if (w >= 300) chk("wait_outs_timeout_count", outq.size(), n);
    repeat (3) tick();
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    ratio     = 4'd0;
    shift     = 4'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;

    // Reset held with random inputs
    repeat (3) begin
      in_valid  = 1'($urandom);
      in_data   = $urandom;
      start     = 1'($urandom);
      ratio     = 4'($urandom);
      shift     = 4'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    @(negedge clk);
    chk("rst_in_ready",   in_ready,   1'b0);
    chk("rst_out_valid",  out_valid,  1'b0);
    chk("rst_out_data",   out_data,   32'd0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_sat_flag",   sat_flag,   1'b0);
    chk("rst_level",      level,      3'd0);
    start = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_level",    level,    3'd0);
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_in_ready", in_ready, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // ratio=3 shift=2, inputs 1..32, group k -> 4k+2, no flush
    do_start(4'd3, 4'd2);
    chk("t2_in_ready_after_start", in_ready, 1'b1);
    for (int i = 1; i <= 32; i++) feed(32'(i));
    chk("t2_frame_done_no_flush", frame_done, 1'b1);
    wait_outs(8);
    chk("t2_count", outq.size(), 8);
    for (int k = 0; k < 8 && k < outq.size(); k++) begin
      chk($sformatf("t2_out%0d", k), outq[k], 32'(4 * k + 2));
      chk($sformatf("t2_lat%0d", k), popc[k], accc[4 * k + 3] + 1);
    end

    // ratio=4 shift=0, 32 ones -> six 5s then flushed 2
    do_start(4'd4, 4'd0);
    chk("t3_frame_done_cleared", frame_done, 1'b0);
    for (int i = 0; i < 32; i++) feed(32'd1);
    chk("t3_frame_done_during_flush", frame_done, 1'b0);
    tick();
    chk("t3_frame_done_after_flush", frame_done, 1'b1);
    wait_outs(7);
    chk("t3_count", outq.size(), 7);
    for (int k = 0; k < 7 && k < outq.size(); k++)
      chk($sformatf("t3_out%0d", k), outq[k], (k < 6) ? 32'd5 : 32'd2);

    // Backpressure: ratio=0, out_ready=0, samples 0x10..0x2F
    out_ready = 1'b0;
    do_start(4'd0, 4'd0);
    for (int i = 0; i < 4; i++) feed(32'h10 + 32'(i));
    chk("t4_level_full", level, 3'd4);
    chk("t4_in_ready_low", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h14;
    repeat (3) tick();
    chk("t4_stalled_accepts", accc.size(), 4);
    chk("t4_stalled_level", level, 3'd4);
    chk("t4_head", out_data, 32'h10);
    out_ready = 1'b1;
    for (int i = 4; i < 32; i++) feed(32'h10 + 32'(i));
    wait_outs(32);
    chk("t4_count", outq.size(), 32);
    for (int k = 0; k < 32 && k < outq.size(); k++)
      chk($sformatf("t4_out%0d", k), outq[k], 32'h10 + 32'(k));
    chk("t4_level_drained", level, 3'd0);
    chk("t4_frame_done", frame_done, 1'b1);

    // Saturation: ratio=15 shift=0
    do_start(4'd15, 4'd0);
    for (int i = 0; i < 16; i++) feed(32'h7FFF_FFFF);
    for (int i = 0; i < 16; i++) feed(32'h8000_0000);
    wait_outs(2);
    chk("t5_count", outq.size(), 2);
`ifdef FIR_DECIM_SAT_EN
    chk("t5_pos", outq[0], 32'h7FFF_FFFF);
    chk("t5_neg", outq[1], 32'h8000_0000);
    chk("t5_sat_flag", sat_flag, 1'b1);
`else
    chk("t5_pos", outq[0], 32'hFFFF_FFF0);
    chk("t5_neg", outq[1], 32'h0000_0000);
    chk("t5_sat_flag", sat_flag, 1'b0);
`endif
    chk("t5_frame_done", frame_done, 1'b1);

    // Restart mid-frame with 2 entries queued
    out_ready = 1'b0;
    do_start(4'd4, 4'd0);
    chk("t6_sat_cleared", sat_flag, 1'b0);
    for (int i = 0; i < 10; i++) feed(32'd7);
    chk("t6_level_before", level, 3'd2);
    chk("t6_head_before", out_data, 32'd35);
    outq.delete();
    popc.delete();
    accc.delete();
    start    = 1'b1;
    ratio    = 4'd3;
    shift    = 4'd2;
    in_valid = 1'b1;
    in_data  = 32'h1000;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("t6_level_after", level, 3'd0);
    chk("t6_out_valid_after", out_valid, 1'b0);
    chk("t6_out_data_after", out_data, 32'd0);
    chk("t6_frame_done_after", frame_done, 1'b0);
    out_ready = 1'b1;
    for (int i = 1; i <= 32; i++) feed(32'(i));
    wait_outs(8);
    chk("t6_count", outq.size(), 8);
    for (int k = 0; k < 8 && k < outq.size(); k++)
      chk($sformatf("t6_out%0d", k), outq[k], 32'(4 * k + 2));
    chk("t6_frame_done", frame_done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
